timer_unit: RTL

- Parametrised memory-mapped interval timer for the MIPS CPU peripheral bus.
- Builds on the existing TH/TL reload-counter timer and adds:
  - configurable counter width
  - programmable prescaler
  - one-shot vs auto-reload mode
  - a sticky overflow flag with a maskable interrupt line to the CPU.
- Written through a single-cycle register port; read combinationally by the load path.

---
 rtl/timer_unit_if.sv | 22 ++
 rtl/timer_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/timer_unit_if.sv
// Register-port bundle between the CPU peripheral bus and timer_unit.
// master: wr_en/wr_addr/wr_data/rd_addr out, rd_data/irq in; slave: mirror.
interface timer_unit_if #(
   parameter int WIDTH = 32
);
   logic             wr_en;
   logic [1:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [1:0]       rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             irq;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr,
      input  rd_data, irq
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr,
      output rd_data, irq
   );
endinterface

// File: rtl/timer_unit.sv
// Interval timer: TL counts prescaled ticks, reloads from TH on overflow.
// Ports: clk, reset (sync, active-high), bus (timer_unit_if.slave).
module timer_unit #(
   parameter int WIDTH   = 32,
   parameter int PRESC_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   timer_unit_if.slave bus
);

   logic [WIDTH-1:0]   th_q, th_d;
   logic [WIDTH-1:0]   tl_q, tl_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] pc_q, pc_d;
   logic               en_q, en_d;
   logic               irq_en_q, irq_en_d;
   logic               flag_q, flag_d;
   logic               oneshot_q, oneshot_d;

   logic wr_th, wr_tl, wr_tcon, wr_presc;
   logic pc_hit, tick, tl_max, ovf;

   always_comb begin
      wr_th    = bus.wr_en && (bus.wr_addr == 2'd0);
      wr_tl    = bus.wr_en && (bus.wr_addr == 2'd1);
      wr_tcon  = bus.wr_en && (bus.wr_addr == 2'd2);
      wr_presc = bus.wr_en && (bus.wr_addr == 2'd3);

      pc_hit = (pc_q == presc_q);
      // A TCON write restarts the prescaler, but a tick already due
      // this cycle still lands so a coincident overflow is not lost.
      tick   = en_q && pc_hit && !wr_presc;
      tl_max = (tl_q == '1);
      // A TL write discards the tick, including its overflow.
      ovf    = tick && tl_max && !wr_tl;

      th_d = wr_th ? bus.wr_data : th_q;

      tl_d = tl_q;
      if (wr_tl) begin
         tl_d = bus.wr_data;
      end else if (tick) begin
         tl_d = tl_max ? th_q : tl_q + WIDTH'(1);
      end

      pc_d = pc_q + PRESC_W'(1);
      if (!en_q || pc_hit || wr_tcon || wr_presc) begin
         pc_d = '0;
      end

      presc_d = presc_q;
      if (wr_presc) begin
         presc_d = bus.wr_data[PRESC_W-1:0];
      end

      irq_en_d  = wr_tcon ? bus.wr_data[1] : irq_en_q;
      oneshot_d = wr_tcon ? bus.wr_data[3] : oneshot_q;
      flag_d    = (wr_tcon ? bus.wr_data[2] : flag_q) | ovf;

      en_d = en_q;
      if (ovf && oneshot_q) begin
         en_d = 1'b0;
      end
      if (wr_tcon) begin
         en_d = bus.wr_data[0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         th_q      <= '0;
         tl_q      <= '0;
         presc_q   <= '0;
         pc_q      <= '0;
         en_q      <= 1'b0;
         irq_en_q  <= 1'b0;
         flag_q    <= 1'b0;
         oneshot_q <= 1'b0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         presc_q   <= presc_d;
         pc_q      <= pc_d;
         en_q      <= en_d;
         irq_en_q  <= irq_en_d;
         flag_q    <= flag_d;
         oneshot_q <= oneshot_d;
      end
   end

   always_comb begin
      bus.rd_data = '0;
      unique case (bus.rd_addr)
         2'd0: bus.rd_data = th_q;
         2'd1: bus.rd_data = tl_q;
         2'd2: bus.rd_data[3:0] = {oneshot_q, flag_q, irq_en_q, en_q};
         2'd3: bus.rd_data[PRESC_W-1:0] = presc_q;
      endcase
   end

   assign bus.irq = flag_q & irq_en_q;

endmodule
